// File: rtl/mfp_pmod_als_spi_responder.sv
// ADC081S021-style responder for the PMOD ALS link: shifts {3'b0, sample, 5'b0}
// out on sdo, MSB first, under externally driven CS/SCK.
module mfp_pmod_als_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       sck,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic [7:0] sample,
    output logic       frame_done,
    output logic       frame_abort
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam int unsigned FLUSH = SYNC_STAGES + 1;
    localparam int unsigned FW    = $clog2(FLUSH + 1);

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
    logic                   cs_d, sck_d;
    logic                   cs_s, sck_s;
    logic                   cs_fall, cs_rise, sck_fall;
    logic [FW-1:0]          flush_cnt;
    logic                   flushed, armed;

    state_t      state, state_n;
    logic [15:0] shift_reg, shift_n;
    logic [4:0]  bit_cnt, cnt_n;
    logic        done_n, abort_n;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign flushed = (flush_cnt == FW'(FLUSH));

    // The chain resets to "idle high", so a CS held low across reset would look
    // like a fresh fall; only accept falls once real pin data has shown CS high.
    assign cs_fall  = armed & cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync     <= '1;
            sck_sync    <= '1;
            cs_d        <= 1'b1;
            sck_d       <= 1'b1;
            flush_cnt   <= '0;
            armed       <= 1'b0;
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_d        <= cs_s;
            sck_d       <= sck_s;
            if (!flushed)
                flush_cnt <= flush_cnt + 1'b1;
            armed       <= armed | (flushed & cs_d);
            state       <= state_n;
            shift_reg   <= shift_n;
            bit_cnt     <= cnt_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = bit_cnt;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    shift_n = {3'b000, sample, 5'b00000};
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // CS release outranks a coincident SCK fall, including the 16th.
                if (cs_rise) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end else if (sck_fall) begin
                    shift_n = {shift_reg[14:0], 1'b0};
                    cnt_n   = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        state_n = HOLD;
                        done_n  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cs_rise)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sdo    = (state == SHIFT) & shift_reg[15];
        sdo_oe = (state != IDLE);
    end

endmodule

// File: tb/tb_mfp_pmod_als_spi_responder.sv
// Self-checking bench for mfp_pmod_als_spi_responder: a bit-banged SPI master
// captures sdo before each SCK fall and compares against a queue of expected words.
module tb_mfp_pmod_als_spi_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs    = 1'b1;
    logic       sck   = 1'b1;
    logic [7:0] sample = 8'h00;
    logic       sdo, sdo_oe, frame_done, frame_abort;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    logic [15:0] exp_q[$];

    int unsigned done_cnt = 0, abort_cnt = 0, done_cyc = 0;
    bit both_seen = 0, long_seen = 0, prev_done = 0, prev_abort = 0;

    mfp_pmod_als_spi_responder #(.SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .cs         (cs),
        .sck        (sck),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe),
        .sample     (sample),
        .frame_done (frame_done),
        .frame_abort(frame_abort)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_abort === 1'b1) abort_cnt = abort_cnt + 1;
        if (frame_done === 1'b1 && frame_abort === 1'b1) both_seen = 1;
        if ((frame_done === 1'b1 && prev_done) || (frame_abort === 1'b1 && prev_abort)) long_seen = 1;
        prev_done  = (frame_done === 1'b1);
        prev_abort = (frame_abort === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // CS low, 8-clock half periods, 16 SCK periods; sdo captured just before each fall.
    task automatic run_frame(input logic [7:0] val, input bit change_mid, input logic [7:0] mid_val,
                             output logic [15:0] word, output int unsigned last_fall_cyc);
        sample = val;
        cs = 1'b0;
        exp_q.push_back({3'b000, val, 5'b00000});
        tick(8);
        word = '0;
        last_fall_cyc = 0;
        for (int i = 0; i < 16; i++) begin
            word = {word[14:0], sdo};
            sck = 1'b0;
            if (i == 15) last_fall_cyc = cyc;
            tick(8);
            if (change_mid && i == 4) sample = mid_val;
            sck = 1'b1;
            tick(8);
        end
    endtask

    task automatic end_frame();
        cs = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cs = 1'b1;
        sck = 1'b1;
        tick(3);
        checks++;
        if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        checks++;
        if (sdo_oe !== 1'b0) begin errors++; $display("FAIL reset_sdo_oe: got %b want 0", sdo_oe); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++;
        if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", frame_abort); end
        reset = 1'b0;
        tick(8);
    endtask

    task automatic test_basic_frame();
        logic [15:0] word, exp;
        int unsigned fall_cyc, d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        run_frame(8'hA5, 0, 8'h00, word, fall_cyc);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin errors++; $display("FAIL basic_word: got %h want %h", word, exp); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        checks++;
        if (done_cyc - fall_cyc != 3) begin errors++; $display("FAIL basic_done_latency: got %0d want 3", done_cyc - fall_cyc); end
        checks++;
        if (abort_cnt != a0) begin errors++; $display("FAIL basic_no_abort: got %0d want %0d", abort_cnt, a0); end
        checks++;
        if (sdo_oe !== 1'b1) begin errors++; $display("FAIL basic_oe_held: got %b want 1", sdo_oe); end
        end_frame();
        checks++;
        if (sdo_oe !== 1'b0 || sdo !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after: got oe=%b sdo=%b want 0 0", sdo_oe, sdo);
        end
    endtask

    task automatic test_sample_change();
        logic [15:0] word, exp;
        int unsigned fall_cyc;
        run_frame(8'hFF, 1, 8'h00, word, fall_cyc);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin errors++; $display("FAIL sample_change_word: got %h want %h", word, exp); end
        end_frame();
    endtask

    task automatic test_abort();
        int unsigned d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        sample = 8'h5A;
        cs = 1'b0;
        tick(8);
        for (int i = 0; i < 6; i++) begin
            sck = 1'b0; tick(8);
            sck = 1'b1; tick(8);
        end
        cs = 1'b1;
        tick(8);
        checks++;
        if (abort_cnt - a0 != 1) begin errors++; $display("FAIL abort_count: got %0d want 1", abort_cnt - a0); end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, d0); end
        checks++;
        if (sdo !== 1'b0 || sdo_oe !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got sdo=%b oe=%b want 0 0", sdo, sdo_oe);
        end
    endtask

    task automatic test_extra_sck();
        logic [15:0] word, exp;
        int unsigned fall_cyc, d0;
        bit bad_sdo, bad_oe;
        d0 = done_cnt;
        run_frame(8'hC3, 0, 8'h00, word, fall_cyc);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin errors++; $display("FAIL extra_word: got %h want %h", word, exp); end
        bad_sdo = 0;
        bad_oe = 0;
        for (int i = 0; i < 4; i++) begin
            sck = 1'b0; tick(8);
            if (sdo !== 1'b0) bad_sdo = 1;
            if (sdo_oe !== 1'b1) bad_oe = 1;
            sck = 1'b1; tick(8);
            if (sdo !== 1'b0) bad_sdo = 1;
        end
        checks++;
        if (bad_sdo) begin errors++; $display("FAIL extra_sdo_zero: got nonzero want 0"); end
        checks++;
        if (bad_oe) begin errors++; $display("FAIL extra_oe_held: got 0 want 1"); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL extra_done_count: got %0d want 1", done_cnt - d0); end
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] word, exp;
        int unsigned fall_cyc, d0, a0;
        bit bad;
        sample = 8'hE7;
        cs = 1'b0;
        tick(8);
        for (int i = 0; i < 9; i++) begin
            sck = 1'b0; tick(8);
            sck = 1'b1; tick(8);
        end
        d0 = done_cnt;
        a0 = abort_cnt;
        reset = 1'b1;
        tick(1);
        checks++;
        if (sdo !== 1'b0 || sdo_oe !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got sdo=%b oe=%b want 0 0", sdo, sdo_oe);
        end
        tick(1);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            sck = 1'b0; tick(8);
            if (sdo !== 1'b0 || sdo_oe !== 1'b0) bad = 1;
            sck = 1'b1; tick(8);
            if (sdo !== 1'b0 || sdo_oe !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midreset_cs_low_ignored: got active want idle"); end
        checks++;
        if (done_cnt != d0 || abort_cnt != a0) begin
            errors++; $display("FAIL midreset_no_pulse: got done+%0d abort+%0d want 0 0", done_cnt - d0, abort_cnt - a0);
        end
        end_frame();
        run_frame(8'h3C, 0, 8'h00, word, fall_cyc);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin errors++; $display("FAIL midreset_next_word: got %h want %h", word, exp); end
        end_frame();
    endtask

    task automatic test_cs_sck_same_cycle();
        logic [15:0] word, exp;
        logic first;
        sample = 8'h80;
        exp_q.push_back({3'b000, sample, 5'b00000});
        cs = 1'b0;
        sck = 1'b0;
        tick(8);
        sck = 1'b1;
        tick(8);
        word = '0;
        first = 1'bx;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) first = sdo;
            word = {word[14:0], sdo};
            sck = 1'b0; tick(8);
            sck = 1'b1; tick(8);
        end
        checks++;
        if (first !== 1'b0) begin errors++; $display("FAIL same_cycle_first_bit: got %b want 0", first); end
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin errors++; $display("FAIL same_cycle_word: got %h want %h", word, exp); end
        end_frame();
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (both_seen) begin errors++; $display("FAIL pulse_exclusive: got both high want never"); end
        checks++;
        if (long_seen) begin errors++; $display("FAIL pulse_width: got >1 cycle want 1"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drained: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_sample_change();
        test_abort();
        test_extra_sck();
        test_reset_mid_frame();
        test_cs_sck_same_cycle();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
